sipo_rx: RTL and testbench

SIPO_RX -- requirements
Module: sipo_rx

---
 rtl/sipo_rx.sv | 106 ++++++++++
 tb/tb_sipo_rx.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_rx.sv
// rtl/sipo_rx.sv - serial-in parallel-out nibble receiver, LSB first, with valid/ready hand-off.
// Optional even-parity fifth bit enabled by defining SIPO_RX_PARITY_EN.
module sipo_rx (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       sin,
  input  logic       start,
  output logic [3:0] dout,
  output logic       valid,
  input  logic       ready,
  output logic       overrun,
  output logic       perr
);

`ifdef SIPO_RX_PARITY_EN
  localparam int FRAME = 5;
`else
  localparam int FRAME = 4;
`endif
  localparam logic [2:0] LAST = 3'(FRAME - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t     state, state_nxt;
  logic [2:0] cnt, cnt_nxt, idx;
  logic [3:0] sr, sr_nxt, frame_data;
  logic       frame_perr, done;
`ifdef SIPO_RX_PARITY_EN
  logic       par, par_nxt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 3'd0;
      sr    <= 4'd0;
`ifdef SIPO_RX_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      sr    <= sr_nxt;
`ifdef SIPO_RX_PARITY_EN
      par   <= par_nxt;
`endif
    end
  end

  // A qualified start restarts the frame at bit 0 regardless of how far we got.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    sr_nxt     = sr;
    done       = 1'b0;
    idx        = start ? 3'd0 : cnt;
`ifdef SIPO_RX_PARITY_EN
    par_nxt    = par;
`endif
    if (en) begin
`ifdef SIPO_RX_PARITY_EN
      if (idx < 3'd4) sr_nxt = {sin, sr[3:1]};
      par_nxt = (idx == 3'd0) ? sin : (par ^ sin);
`else
      sr_nxt = {sin, sr[3:1]};
`endif
      if (idx == LAST) begin
        done      = 1'b1;
        cnt_nxt   = 3'd0;
        state_nxt = IDLE;
      end else begin
        cnt_nxt   = idx + 3'd1;
        state_nxt = SHIFT;
      end
    end
`ifdef SIPO_RX_PARITY_EN
    frame_data = sr;
    frame_perr = par ^ sin;
`else
    frame_data = sr_nxt;
    frame_perr = 1'b0;
`endif
  end

  // A completed frame replaces dout only if the holding slot is free or draining.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout    <= 4'd0;
      valid   <= 1'b0;
      overrun <= 1'b0;
      perr    <= 1'b0;
    end else if (done) begin
      if (!valid || ready) begin
        dout  <= frame_data;
        perr  <= frame_perr;
        valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sipo_rx.sv
// tb/tb_sipo_rx.sv - self-checking bench for sipo_rx with a queue-based frame model.
module tb_sipo_rx;

`ifdef SIPO_RX_PARITY_EN
  localparam int FRAME = 5;
`else
  localparam int FRAME = 4;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, sin = 1'b0, start = 1'b0, ready = 1'b0;
  logic [3:0] dout;
  logic       valid, overrun, perr;

  int checks = 0;
  int errors = 0;

  logic [3:0] m_dout;
  logic       m_valid, m_ovr, m_perr;
  int         bits[$];

  sipo_rx dut (
    .clk(clk), .rst(rst), .en(en), .sin(sin), .start(start),
    .dout(dout), .valid(valid), .ready(ready), .overrun(overrun), .perr(perr)
  );

  always #5 clk = ~clk;

  // Model: collect bits in a queue; a full queue is one frame, value = sum of bit_i * 2^i.
  task automatic model_edge();
    bit done = 0;
    int nib = 0;
    int px = 0;
    if (rst) begin
      bits.delete();
      m_dout = 0; m_valid = 0; m_ovr = 0; m_perr = 0;
      return;
    end
    if (en) begin
      if (start) bits.delete();
      bits.push_back(int'(sin));
      if (bits.size() == FRAME) begin
        done = 1;
        for (int i = 0; i < 4; i++) nib += bits[i] * (1 << i);
        for (int i = 0; i < FRAME; i++) px += bits[i];
        bits.delete();
      end
    end
    if (done) begin
      if (!m_valid || ready) begin
        m_dout = 4'(nib);
        m_perr = (FRAME == 5) ? logic'(px % 2) : 1'b0;
        m_valid = 1;
      end else begin
        m_ovr = 1;
      end
    end else if (m_valid && ready) begin
      m_valid = 0;
    end
  endtask

  task automatic step(input logic e, input logic s, input logic st, input logic r, input logic rs);
    en = e; sin = s; start = st; ready = r; rst = rs;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [3:0] n, input logic st, input logic rdy_last);
    logic p;
    p = ^n;
    for (int i = 0; i < FRAME; i++) begin
      if (i < 4) step(1, n[i], (i == 0) ? st : 1'b0, (i == FRAME - 1) ? rdy_last : 1'b0, 0);
      else       step(1, p, 0, rdy_last, 0);
    end
  endtask

  task automatic test_reset();
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    checks++;
    if ({dout, valid, overrun, perr} !== 7'd0) begin
      errors++;
      $display("FAIL reset_outputs: got dout=%h valid=%b ovr=%b perr=%b expected all 0", dout, valid, overrun, perr);
    end
    step(0, 0, 0, 0, 0);
  endtask

  task automatic test_basic();
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    checks++;
    if (valid !== 1'b0) begin
      errors++; $display("FAIL basic_early_valid: got %b expected 0", valid);
    end
    step(1, 1, 0, 0, 0);
    if (FRAME == 5) step(1, 1, 0, 0, 0);
    checks++;
    if (dout !== 4'hD || valid !== 1'b1 || perr !== 1'b0) begin
      errors++; $display("FAIL basic_frame: got dout=%h valid=%b perr=%b expected D 1 0", dout, valid, perr);
    end
  endtask

  task automatic test_overrun();
    send_frame(4'h3, 0, 0);
    checks++;
    if (dout !== 4'hD || valid !== 1'b1 || overrun !== 1'b1) begin
      errors++; $display("FAIL overrun_drop: got dout=%h valid=%b ovr=%b expected D 1 1", dout, valid, overrun);
    end
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    checks++;
    if (overrun !== 1'b1 || valid !== 1'b0) begin
      errors++; $display("FAIL overrun_sticky: got ovr=%b valid=%b expected 1 0", overrun, valid);
    end
  endtask

  task automatic test_simultaneous();
    step(0, 0, 0, 0, 1);
    send_frame(4'hD, 0, 0);
    send_frame(4'h6, 0, 1);
    checks++;
    if (dout !== 4'h6 || valid !== 1'b1 || overrun !== 1'b0) begin
      errors++; $display("FAIL drain_fill: got dout=%h valid=%b ovr=%b expected 6 1 0", dout, valid, overrun);
    end
    step(0, 0, 0, 1, 0);
    checks++;
    if (valid !== 1'b0 || dout !== 4'h6) begin
      errors++; $display("FAIL drain_clear: got valid=%b dout=%h expected 0 6", valid, dout);
    end
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 0, 0);
    checks++;
    if (valid !== 1'b0) begin
      errors++; $display("FAIL start_without_en: got valid=%b expected 0", valid);
    end
  endtask

  task automatic test_start_realign();
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    send_frame(4'hA, 1, 0);
    checks++;
    if (dout !== 4'hA || valid !== 1'b1) begin
      errors++; $display("FAIL realign: got dout=%h valid=%b expected A 1", dout, valid);
    end
    step(0, 0, 0, 1, 0);
  endtask

  task automatic test_reset_midframe();
    step(1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    checks++;
    if (valid !== 1'b0) begin
      errors++; $display("FAIL gap_no_advance: got valid=%b expected 0", valid);
    end
    step(1, 0, 0, 0, 0);
    if (FRAME == 5) step(1, 0, 0, 0, 0);
    checks++;
    if (dout !== 4'h5 || valid !== 1'b1 || overrun !== 1'b0) begin
      errors++; $display("FAIL reset_midframe: got dout=%h valid=%b ovr=%b expected 5 1 0", dout, valid, overrun);
    end
    step(0, 0, 0, 1, 0);
  endtask

`ifdef SIPO_RX_PARITY_EN
  task automatic test_parity();
    step(0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0); step(1, 1, 0, 0, 0); step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0); step(1, 1, 0, 0, 0);
    checks++;
    if (dout !== 4'h3 || perr !== 1'b1 || valid !== 1'b1) begin
      errors++; $display("FAIL parity_bad: got dout=%h perr=%b valid=%b expected 3 1 1", dout, perr, valid);
    end
    step(1, 1, 0, 0, 0); step(1, 1, 0, 0, 0); step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0); step(1, 0, 0, 1, 0);
    checks++;
    if (dout !== 4'h3 || perr !== 1'b0 || valid !== 1'b1) begin
      errors++; $display("FAIL parity_good: got dout=%h perr=%b valid=%b expected 3 0 1", dout, perr, valid);
    end
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      step(($urandom % 10) < 6, $urandom % 2, ($urandom % 10) == 0,
           $urandom % 2, ($urandom % 100) < 2);
      checks++;
      if (dout !== m_dout || valid !== m_valid || overrun !== m_ovr || perr !== m_perr) begin
        errors++;
        $display("FAIL random_cycle %0d: got dout=%h v=%b o=%b p=%b expected dout=%h v=%b o=%b p=%b",
                 c, dout, valid, overrun, perr, m_dout, m_valid, m_ovr, m_perr);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_overrun();
    test_simultaneous();
    test_start_realign();
    test_reset_midframe();
`ifdef SIPO_RX_PARITY_EN
    test_parity();
`endif
    step(0, 0, 0, 0, 1);
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
